// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared types and constants for the Z80 IM2 interrupt controller
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_VBASE = 2'd1;
  localparam logic [1:0] ADDR_PEND  = 2'd2;
  localparam logic [1:0] ADDR_ISR   = 2'd3;

  localparam int VEC_IDX_W = 3;

  // IM2 vector byte: upper nibble from VBASE, source index in bits 3:1, bit 0 always clear
  function automatic logic [7:0] make_vector(input logic [7:0] vbase, input logic [VEC_IDX_W-1:0] idx);
    return {vbase[7:4], idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_controller_prio_encoder.sv
// rtl/irq_controller_prio_encoder.sv - fixed-priority encoder, highest set index wins
module prio_encoder
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_vec,
  output logic [VEC_IDX_W-1:0] o_idx,
  output logic                 o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx = VEC_IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - Z80 mode-2 interrupt controller; IRQ_CTRL_NESTING_EN enables priority preemption
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int INPUT_QTY = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INPUT_QTY-1:0] irq_in,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic [7:0]           cfg_rdata,
  input  logic                 m1_n,
  input  logic                 iorq_n,
  output logic                 int_n,
  output logic                 vec_oe,
  output logic [7:0]           vec_data
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INPUT_QTY-1:0]   r_irq_prev;
  logic [INPUT_QTY-1:0]   r_pending;
  logic [INPUT_QTY-1:0]   r_mask;
  logic [INPUT_QTY-1:0]   r_isr;
  logic [7:0]             r_vbase;
  logic [VEC_IDX_W-1:0]   r_win_idx;
  logic                   r_int_n;
  logic                   r_vec_oe;
  logic [7:0]             r_vec_data;

  logic [INPUT_QTY-1:0]   w_edge;
  logic [INPUT_QTY-1:0]   w_eligible;
  logic [VEC_IDX_W-1:0]   w_win;
  logic                   w_win_any;
  logic [VEC_IDX_W-1:0]   w_isr_top;
  logic                   w_isr_any;
  logic                   w_blocked;
  logic                   w_inta;
  logic                   w_take;
  logic                   w_ack;
  logic                   w_done;
  logic                   w_eoi;
  logic [INPUT_QTY-1:0]   w_win_oh;
  logic [INPUT_QTY-1:0]   w_isr_oh;

  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_eligible = r_pending & r_mask;
  assign w_inta     = !m1_n && !iorq_n;
  assign w_eoi      = cfg_we && (cfg_addr == ADDR_ISR) && w_isr_any;
  assign w_win_oh   = INPUT_QTY'(1) << r_win_idx;
  assign w_isr_oh   = INPUT_QTY'(1) << w_isr_top;

  prio_encoder #(.N(INPUT_QTY)) u_win_enc (
    .i_vec (w_eligible),
    .o_idx (w_win),
    .o_any (w_win_any)
  );

  prio_encoder #(.N(INPUT_QTY)) u_isr_enc (
    .i_vec (r_isr),
    .o_idx (w_isr_top),
    .o_any (w_isr_any)
  );

`ifdef IRQ_CTRL_NESTING_EN
  assign w_blocked = w_isr_any && (w_win <= w_isr_top);
`else
  assign w_blocked = w_isr_any;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ack       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (w_win_any && !w_blocked) begin
        w_take      = 1'b1;
        w_state_nxt = REQ;
      end
      REQ: if (w_inta) begin
        w_ack       = 1'b1;
        w_state_nxt = ACK;
      end
      ACK: if (!w_inta) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_isr      <= '0;
      r_vbase    <= '0;
      r_win_idx  <= '0;
      r_int_n    <= 1'b1;
      r_vec_oe   <= 1'b0;
      r_vec_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= irq_in;
      // A fresh edge on the acknowledged source survives the ack clear
      r_pending  <= (r_pending & ~(w_ack ? w_win_oh : '0)) | w_edge;
      r_isr      <= (r_isr & ~(w_eoi ? w_isr_oh : '0)) | (w_ack ? w_win_oh : '0);
      if (cfg_we && cfg_addr == ADDR_MASK)  r_mask  <= cfg_wdata[INPUT_QTY-1:0];
      if (cfg_we && cfg_addr == ADDR_VBASE) r_vbase <= cfg_wdata;
      if (w_take) begin
        r_win_idx <= w_win;
        r_int_n   <= 1'b0;
      end
      if (w_ack) begin
        r_int_n    <= 1'b1;
        r_vec_oe   <= 1'b1;
        r_vec_data <= make_vector(r_vbase, r_win_idx);
      end
      if (w_done) r_vec_oe <= 1'b0;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK:  cfg_rdata = 8'(r_mask);
      ADDR_VBASE: cfg_rdata = r_vbase;
      ADDR_PEND:  cfg_rdata = 8'(r_pending);
      ADDR_ISR:   cfg_rdata = 8'(r_isr);
      default:    cfg_rdata = '0;
    endcase
  end

  assign int_n    = r_int_n;
  assign vec_oe   = r_vec_oe;
  assign vec_data = r_vec_data;

endmodule
